// File: rtl/aes_iter_encrypt.sv
// aes_iter_encrypt: iterative AES-128/192/256 encryption, one round per clock.
// Optional `AES_KEY_LATCH_EN: capture the key schedule on accept so the source may change mid-block.
module aes_iter_encrypt #(
  parameter int unsigned NK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              d_in,
  input  logic [0:4*(NK+7)-1][31:0] key_schedule,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              d_out,
  output logic                      busy
);
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned RW = $clog2(NR + 1);

  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_iter_encrypt: NK must be 4, 6 or 8");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254 by square-and-multiply) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, v;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    v = gf_mul(gf_mul(x240, x12), x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic blk_t sub_bytes(input blk_t s);
    blk_t o;
    for (int i = 0; i < 16; i++) o[4'(i)] = sbox(s[4'(i)]);
    return o;
  endfunction

  // Byte 4c+r is row r, column c; row r rotates left by r columns
  function automatic blk_t shift_rows(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4'(4 * c + r)] = s[4'(4 * ((c + r) % 4) + r)];
    return o;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4'(4 * c)];
      a1 = s[4'(4 * c + 1)];
      a2 = s[4'(4 * c + 2)];
      a3 = s[4'(4 * c + 3)];
      o[4'(4 * c)]     = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[4'(4 * c + 1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[4'(4 * c + 2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[4'(4 * c + 3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  state_t              state;
  logic [RW-1:0]       rnd;
  blk_t                st;
  blk_t                sb, sr, mc;
  logic [0:NW-1][31:0] ks_use;
  logic [127:0]        rkeys [NR+1];
  logic [127:0]        rk, round_out, final_out, init_out;
  logic                accept;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef AES_KEY_LATCH_EN
  logic [0:NW-1][31:0] key_q;

  // Private copy of the schedule for the block in flight
  always_ff @(posedge clk) begin
    if (accept) key_q <= key_schedule;
  end
  assign ks_use = key_q;
`else
  assign ks_use = key_schedule;
`endif

  for (genvar g = 0; g <= NR; g++) begin : g_rk
    assign rkeys[g] = {ks_use[4*g], ks_use[4*g+1], ks_use[4*g+2], ks_use[4*g+3]};
  end

  assign sb        = sub_bytes(st);
  assign sr        = shift_rows(sb);
  assign mc        = mix_columns(sr);
  assign rk        = rkeys[rnd];
  assign round_out = mc ^ rk;
  assign final_out = sr ^ rk;
  // Whitening always uses the live schedule: the latched copy is only written on this edge
  assign init_out  = d_in ^ {key_schedule[0], key_schedule[1], key_schedule[2], key_schedule[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      st        <= '0;
      d_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      st        <= init_out;
      rnd       <= RW'(1);
      busy      <= 1'b1;
      out_valid <= 1'b0;
      state     <= ROUND;
    end else begin
      case (state)
        ROUND: begin
          if (rnd == RW'(NR)) begin
            d_out     <= final_out;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            st  <= round_out;
            rnd <= rnd + RW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// tb_aes_iter_encrypt: AES-128/192/256 iterative core against a byte-matrix reference model.
// Build with +define+AES_KEY_LATCH_EN to also exercise key-schedule latching.
`timescale 1ns/1ps
module tb_aes_iter_encrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, out_ready;
  logic [127:0]      d_in;
  logic [0:43][31:0] ks4;
  logic [0:51][31:0] ks6;
  logic [0:59][31:0] ks8;
  logic              in_ready4, in_ready6, in_ready8;
  logic              out_valid4, out_valid6, out_valid8;
  logic              busy4, busy6, busy8;
  logic [127:0]      d_out4, d_out6, d_out8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sbox_t [256];

  aes_iter_encrypt #(.NK(4)) u_nk4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .d_in(d_in),
    .key_schedule(ks4), .out_valid(out_valid4), .out_ready(out_ready), .d_out(d_out4), .busy(busy4));
  aes_iter_encrypt #(.NK(6)) u_nk6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6), .d_in(d_in),
    .key_schedule(ks6), .out_valid(out_valid6), .out_ready(out_ready), .d_out(d_out6), .busy(busy6));
  aes_iter_encrypt #(.NK(8)) u_nk8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .d_in(d_in),
    .key_schedule(ks8), .out_valid(out_valid8), .out_ready(out_ready), .d_out(d_out8), .busy(busy8));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rl8(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Table built by walking the multiplicative group with generator 3 and its inverse
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // Key expansion: key words are taken MSB-first from the 256-bit key
  function automatic void expand(input logic [255:0] key, input int nk, output logic [31:0] w [60]);
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   m [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    expand(key, nk, w);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = pt[127-8*(4*c+r) -: 8];
    for (int rd = 0; rd <= nr; rd++) begin
      if (rd > 0) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) m[r][c] = sbox_t[m[r][c]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][c] = m[r][(c + r) % 4];
        m = t;
        if (rd < nr) begin
          for (int c = 0; c < 4; c++) begin
            a0 = m[0][c]; a1 = m[1][c]; a2 = m[2][c]; a3 = m[3][c];
            m[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            m[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            m[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            m[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) m[r][c] ^= w[4*rd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = m[r][c];
    return res;
  endfunction

  task automatic load_keys(input logic [255:0] key);
    logic [31:0] w [60];
    expand(key, 4, w);
    for (int j = 0; j < 44; j++) ks4[j] = w[j];
    expand(key, 6, w);
    for (int j = 0; j < 52; j++) ks6[j] = w[j];
    expand(key, 8, w);
    for (int j = 0; j < 60; j++) ks8[j] = w[j];
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block through all three key lengths; latency counted in edges after the accept edge
  task automatic run_all(input string tag, input logic [255:0] key, input logic [127:0] pt,
                         output logic [127:0] r4, output logic [127:0] r6, output logic [127:0] r8);
    int lat4, lat6, lat8;
    lat4 = 0; lat6 = 0; lat8 = 0;
    r4 = 'x; r6 = 'x; r8 = 'x;
    load_keys(key);
    d_in = pt;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid4 && lat4 == 0) begin lat4 = n; r4 = d_out4; end
      if (out_valid6 && lat6 == 0) begin lat6 = n; r6 = d_out6; end
      if (out_valid8 && lat8 == 0) begin lat8 = n; r8 = d_out8; end
      if (lat4 != 0 && lat6 != 0 && lat8 != 0) break;
    end
    tick();
    check({tag, "_lat4"}, 128'(lat4), 128'd10);
    check({tag, "_lat6"}, 128'(lat6), 128'd12);
    check({tag, "_lat8"}, 128'(lat8), 128'd14);
    check({tag, "_ct4"}, r4, aes_ref(key, 4, pt));
    check({tag, "_ct6"}, r6, aes_ref(key, 6, pt));
    check({tag, "_ct8"}, r8, aes_ref(key, 8, pt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] r4, r6, r8, held, pt, pt2;
    logic [255:0] key;
    logic [127:0] blocks [4];
    logic [127:0] res [4];
    int           tout [4];
    int           idx, nout, lat;
    logic         acc;

    build_sbox();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d_in = '0;
    ks4 = '0; ks6 = '0; ks8 = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", 128'(in_ready4), 128'd1);
    check("rst_out_valid", 128'(out_valid4), 128'd0);
    check("rst_busy", 128'(busy4), 128'd0);
    check("rst_d_out", d_out4, 128'd0);

    run_all("fips_b", {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
            128'h3243f6a8885a308d313198a2e0370734, r4, r6, r8);
    check("fips_b_const", r4, 128'h3925841d02dc09fbdc118597196a0b32);

    run_all("fips_c", 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h00112233445566778899aabbccddeeff, r4, r6, r8);
    check("fips_c1_const", r4, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("fips_c2_const", r6, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    check("fips_c3_const", r8, 128'h8ea2b7ca516745bfeafc49904b496089);

    for (int i = 0; i < 5; i++) run_all("rand", rand_key(), rand_blk(), r4, r6, r8);

    // Back-to-back: in_valid and out_ready held high for four blocks
    key = rand_key();
    load_keys(key);
    blocks[0] = 128'h6162636465666768696a6b6c6d6e7a7a;
    blocks[1] = {8'ha1, blocks[0][119:0]};
    blocks[2] = {8'hb1, blocks[0][119:0]};
    blocks[3] = {8'hc1, blocks[0][119:0]};
    idx = 0; nout = 0;
    d_in = blocks[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 100 && nout < 4; n++) begin
      acc = in_valid && in_ready4;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) d_in = blocks[idx];
        else in_valid = 1'b0;
      end
      if (out_valid4) begin
        res[nout] = d_out4;
        tout[nout] = n;
        nout++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 128'(nout), 128'd4);
    for (int k = 0; k < nout; k++) begin
      check("b2b_ct", res[k], aes_ref(key, 4, blocks[k]));
      if (k > 0) check("b2b_gap", 128'(tout[k] - tout[k-1]), 128'd11);
    end
    repeat (16) tick();

    // Backpressure: result must hold while out_ready is low
    key = rand_key(); pt = rand_blk(); pt2 = rand_blk();
    load_keys(key);
    d_in = pt; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid4) begin lat = n; break; end
    end
    check("bp_lat", 128'(lat), 128'd10);
    held = d_out4;
    check("bp_ct", held, aes_ref(key, 4, pt));
    d_in = pt2; in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      check("bp_hold_d_out", d_out4, held);
      check("bp_hold_valid", 128'(out_valid4), 128'd1);
      check("bp_in_ready", 128'(in_ready4), 128'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 128'(in_ready4), 128'd1);
    tick();
    in_valid = 1'b0;
    check("bp_reload_valid", 128'(out_valid4), 128'd0);
    check("bp_reload_busy", 128'(busy4), 128'd1);
    check("bp_reload_ready", 128'(in_ready4), 128'd0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid4) begin lat = n; break; end
    end
    check("bp2_lat", 128'(lat), 128'd10);
    check("bp2_ct", d_out4, aes_ref(key, 4, pt2));
    repeat (16) tick();

    // Reset in the middle of a block
    d_in = rand_blk(); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("mid_busy", 128'(busy4), 128'd1);
    check("mid_in_ready", 128'(in_ready4), 128'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out_valid", 128'(out_valid4), 128'd0);
    check("mrst_d_out", d_out4, 128'd0);
    check("mrst_in_ready", 128'(in_ready4), 128'd1);
    check("mrst_busy", 128'(busy4), 128'd0);
    run_all("post_rst", rand_key(), rand_blk(), r4, r6, r8);

`ifdef AES_KEY_LATCH_EN
    key = rand_key(); pt = rand_blk();
    load_keys(key);
    d_in = pt; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) begin ks4 = '1; ks6 = '1; ks8 = '1; end
      if (out_valid4) begin lat = n; break; end
    end
    check("latch_lat", 128'(lat), 128'd10);
    check("latch_ct", d_out4, aes_ref(key, 4, pt));
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
